// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - JTAG TAP state encodings, default widths and TAP next-state function
package jtag_pkg;

    localparam int ADR_W_DEF  = 24;
    localparam int LEN_W_DEF  = 24;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [3:0] {
        TLR   = 4'h0,
        RTI   = 4'h1,
        SELDR = 4'h2,
        SELIR = 4'h3,
        CAPDR = 4'h4,
        CAPIR = 4'h5,
        SHDR  = 4'h6,
        SHIR  = 4'h7,
        EX1DR = 4'h8,
        EX1IR = 4'h9,
        PADR  = 4'hA,
        PAIR  = 4'hB,
        EX2DR = 4'hC,
        EX2IR = 4'hD,
        UPDR  = 4'hE,
        UPIR  = 4'hF
    } tap_state_t;

    // IEEE 1149.1 TAP transition; anything unexpected falls back to Test-Logic-Reset
    function automatic tap_state_t next_tap_state(input tap_state_t state, input logic tms);
        tap_state_t nxt;
        nxt = TLR;
        case (state)
            TLR:   nxt = tms ? TLR   : RTI;
            RTI:   nxt = tms ? SELDR : RTI;
            SELDR: nxt = tms ? SELIR : CAPDR;
            SELIR: nxt = tms ? TLR   : CAPIR;
            CAPDR: nxt = tms ? EX1DR : SHDR;
            CAPIR: nxt = tms ? EX1IR : SHIR;
            SHDR:  nxt = tms ? EX1DR : SHDR;
            SHIR:  nxt = tms ? EX1IR : SHIR;
            EX1DR: nxt = tms ? UPDR  : PADR;
            EX1IR: nxt = tms ? UPIR  : PAIR;
            PADR:  nxt = tms ? EX2DR : PADR;
            PAIR:  nxt = tms ? EX2IR : PAIR;
            EX2DR: nxt = tms ? UPDR  : SHDR;
            EX2IR: nxt = tms ? UPIR  : SHIR;
            UPDR:  nxt = tms ? SELDR : RTI;
            UPIR:  nxt = tms ? SELDR : RTI;
            default: nxt = TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tdi_capture_unit_if.sv
// rtl/tdi_capture_unit_if.sv - scan input and capture-RAM write bundle for tdi_capture_unit
interface tdi_capture_unit_if
    import jtag_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              enable;
    logic              tms;
    logic              tdi;
    logic [ADR_W-1:0]  start_adr;
    logic [LEN_W-1:0]  len;
    logic [ADR_W-1:0]  wr_adr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [3:0]        tap_state;
    logic [LEN_W-1:0]  bits_rcvd;
    logic              scan_done;
    logic              overrun;

    modport master (
        output enable, tms, tdi, start_adr, len,
        input  wr_adr, wr_data, wr_en, tap_state, bits_rcvd, scan_done, overrun
    );

    modport slave (
        input  enable, tms, tdi, start_adr, len,
        output wr_adr, wr_data, wr_en, tap_state, bits_rcvd, scan_done, overrun
    );
endinterface

// File: rtl/tap_state_tracker.sv
// rtl/tap_state_tracker.sv - 16-state TAP tracker following the TMS stream
module tap_state_tracker
    import jtag_pkg::*;
(
    input  logic       clk_scan,
    input  logic       reset,
    input  logic       tms,
    output tap_state_t tap_state
);
    tap_state_t state_q;
    tap_state_t state_d;

    // state register, back to Test-Logic-Reset on reset
    always_ff @(posedge clk_scan or posedge reset) begin
        if (reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // next state from the shared TAP transition function
    always_comb begin
        state_d = TLR;
        state_d = next_tap_state(state_q, tms);
    end

    assign tap_state = state_q;
endmodule

// File: rtl/tdi_capture_unit.sv
// rtl/tdi_capture_unit.sv - samples tdi in Shift-DR/IR, packs LSB-first bytes and writes them to capture RAM
module tdi_capture_unit
    import jtag_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic               clk_scan,
    input  logic               reset,
    tdi_capture_unit_if.slave  bus
);
    // bit index must be able to hold DATA_W itself to flag a full word
    localparam int IDX_W = $clog2(DATA_W) + 1;

    tap_state_t        state;
    logic [ADR_W-1:0]  adr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_n;
    logic [DATA_W-1:0] tdi_bit;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_n;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  rem_n;
    logic [LEN_W-1:0]  rcvd_q;
    logic              wr_en_q;
    logic              ovr_q;
    logic              in_shift;
    logic              in_cap;
    logic              exit_shift;
    logic              accept;
    logic              spill;
    logic              do_write;

    tap_state_tracker u_tracker (
        .clk_scan  (clk_scan),
        .reset     (reset),
        .tms       (bus.tms),
        .tap_state (state)
    );

    // decode the bit presented at this edge and whether it closes a word
    always_comb begin
        in_shift   = (state == SHDR) || (state == SHIR);
        in_cap     = (state == CAPDR) || (state == CAPIR);
        exit_shift = in_shift && bus.tms;
        accept     = in_shift && bus.enable && (rem_q != '0);
        spill      = in_shift && bus.enable && (rem_q == '0);
        tdi_bit    = {{(DATA_W-1){1'b0}}, bus.tdi} << idx_q;
        sr_n       = sr_q;
        idx_n      = idx_q;
        rem_n      = rem_q;
        if (accept) begin
            sr_n  = sr_q | tdi_bit;
            idx_n = idx_q + IDX_W'(1);
            rem_n = rem_q - LEN_W'(1);
        end
        // full word, shift exit or last allowed bit: a single write covers all three
        do_write = (idx_n != '0) &&
                   ((idx_n == IDX_W'(DATA_W)) || exit_shift || (accept && (rem_n == '0)));
    end

    // counters, packing register and write strobe
    always_ff @(posedge clk_scan or posedge reset) begin
        if (reset) begin
            adr_q   <= '0;
            data_q  <= '0;
            sr_q    <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            rcvd_q  <= '0;
            wr_en_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (in_cap) begin
            adr_q   <= bus.start_adr;
            rem_q   <= bus.len;
            rcvd_q  <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            ovr_q   <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= do_write;
            // address advances once the write that used it has been presented
            if (wr_en_q) begin
                adr_q <= adr_q + ADR_W'(1);
            end
            if (do_write) begin
                data_q <= sr_n;
                sr_q   <= '0;
                idx_q  <= '0;
            end else begin
                sr_q   <= sr_n;
                idx_q  <= idx_n;
            end
            rem_q <= rem_n;
            if (accept) begin
                rcvd_q <= rcvd_q + LEN_W'(1);
            end
            if (spill) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign bus.wr_adr    = adr_q;
    assign bus.wr_data   = data_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.tap_state = state;
    assign bus.bits_rcvd = rcvd_q;
    assign bus.scan_done = (state == UPDR) || (state == UPIR);
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_tdi_capture_unit.sv
// tb/tb_tdi_capture_unit.sv - directed table and sequence bench for tdi_capture_unit
module tb_tdi_capture_unit;

    typedef struct {
        logic        tms;
        logic        tdi;
        logic [3:0]  st;
        logic        we;
        logic [7:0]  dat;
        logic [23:0] adr;
        logic [23:0] bits;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic [31:0] wq[$];
    vec_t tbl[$];

    tdi_capture_unit_if bus ();

    tdi_capture_unit dut (
        .clk_scan (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // log every write strobe seen mid-cycle
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wq.push_back({bus.wr_adr, bus.wr_data});
    end

    function automatic vec_t mk(input logic tms, input logic tdi, input logic [3:0] st,
                                input logic we, input logic [7:0] dat, input logic [23:0] adr,
                                input logic [23:0] bits, input logic done);
        vec_t v;
        v.tms = tms; v.tdi = tdi; v.st = st; v.we = we;
        v.dat = dat; v.adr = adr; v.bits = bits; v.done = done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic edge_step(input logic tms_v, input logic tdi_v);
        @(negedge clk);
        bus.tms = tms_v;
        bus.tdi = tdi_v;
        @(posedge clk);
        #1;
    endtask

    task automatic to_shift(input bit ir);
        edge_step(1'b1, 1'b0);
        if (ir) edge_step(1'b1, 1'b0);
        edge_step(1'b0, 1'b0);
        edge_step(1'b0, 1'b0);
    endtask

    task automatic shift(input int n, input logic [31:0] pat, input bit exit_last);
        for (int i = 0; i < n; i++) edge_step(exit_last && (i == n - 1), pat[i]);
    endtask

    logic [3:0] exp5 [5];
    logic       don5 [5];

    initial begin
        // DR scan, start 0x100, len 12, bits A5 then nibble 3
        tbl.push_back(mk(1, 0, 4'h2, 0, 8'h00, 24'h000000, 0, 0));
        tbl.push_back(mk(0, 0, 4'h4, 0, 8'h00, 24'h000000, 0, 0));
        tbl.push_back(mk(0, 0, 4'h6, 0, 8'h00, 24'h000100, 0, 0));
        tbl.push_back(mk(0, 1, 4'h6, 0, 8'h00, 24'h000100, 1, 0));
        tbl.push_back(mk(0, 0, 4'h6, 0, 8'h00, 24'h000100, 2, 0));
        tbl.push_back(mk(0, 1, 4'h6, 0, 8'h00, 24'h000100, 3, 0));
        tbl.push_back(mk(0, 0, 4'h6, 0, 8'h00, 24'h000100, 4, 0));
        tbl.push_back(mk(0, 0, 4'h6, 0, 8'h00, 24'h000100, 5, 0));
        tbl.push_back(mk(0, 1, 4'h6, 0, 8'h00, 24'h000100, 6, 0));
        tbl.push_back(mk(0, 0, 4'h6, 0, 8'h00, 24'h000100, 7, 0));
        tbl.push_back(mk(0, 1, 4'h6, 1, 8'hA5, 24'h000100, 8, 0));
        tbl.push_back(mk(0, 1, 4'h6, 0, 8'h00, 24'h000101, 9, 0));
        tbl.push_back(mk(0, 1, 4'h6, 0, 8'h00, 24'h000101, 10, 0));
        tbl.push_back(mk(0, 0, 4'h6, 0, 8'h00, 24'h000101, 11, 0));
        tbl.push_back(mk(1, 0, 4'h8, 1, 8'h03, 24'h000101, 12, 0));
        tbl.push_back(mk(1, 0, 4'hE, 0, 8'h00, 24'h000102, 12, 1));
        tbl.push_back(mk(0, 0, 4'h1, 0, 8'h00, 24'h000102, 12, 0));
        exp5 = '{4'h8, 4'hE, 4'h2, 4'h3, 4'h0};
        don5 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        bus.enable = 1'b1; bus.tms = 1'b0; bus.tdi = 1'b0;
        bus.start_adr = '0; bus.len = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_state", bus.tap_state, 4'h0);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_wr_adr", bus.wr_adr, 24'h0);
        chk("rst_bits", bus.bits_rcvd, 24'h0);
        chk("rst_overrun", bus.overrun, 1'b0);
        chk("rst_done", bus.scan_done, 1'b0);
        @(negedge clk); reset = 1'b0;
        edge_step(1'b0, 1'b0);
        chk("rst_to_rti", bus.tap_state, 4'h1);

        // table-driven DR scan
        bus.start_adr = 24'h000100; bus.len = 24'd12;
        for (int i = 0; i < tbl.size(); i++) begin
            edge_step(tbl[i].tms, tbl[i].tdi);
            chk($sformatf("t2r%0d_state", i), bus.tap_state, tbl[i].st);
            chk($sformatf("t2r%0d_wr_en", i), bus.wr_en, tbl[i].we);
            if (tbl[i].we) chk($sformatf("t2r%0d_data", i), bus.wr_data, tbl[i].dat);
            chk($sformatf("t2r%0d_adr", i), bus.wr_adr, tbl[i].adr);
            chk($sformatf("t2r%0d_bits", i), bus.bits_rcvd, tbl[i].bits);
            chk($sformatf("t2r%0d_done", i), bus.scan_done, tbl[i].done);
        end

        // IR scan with overrun and address wrap
        wq.delete();
        bus.start_adr = 24'hFFFFFF; bus.len = 24'd8;
        to_shift(1'b1);
        chk("t3_in_shir", bus.tap_state, 4'h7);
        shift(10, 32'h3C3, 1'b1);
        chk("t3_ex1ir", bus.tap_state, 4'h9);
        chk("t3_overrun", bus.overrun, 1'b1);
        chk("t3_bits", bus.bits_rcvd, 24'd8);
        chk("t3_adr_wrap", bus.wr_adr, 24'h000000);
        edge_step(1'b1, 1'b0);
        chk("t3_upir", bus.tap_state, 4'hF);
        chk("t3_done", bus.scan_done, 1'b1);
        edge_step(1'b0, 1'b0);
        chk("t3_nwr", wq.size(), 1);
        if (wq.size() > 0) chk("t3_wr0", wq[0], 32'hFFFFFFC3);

        // len=0 scan, walk to TLR with tms=1
        wq.delete();
        bus.start_adr = 24'h000300; bus.len = 24'd0;
        to_shift(1'b0);
        chk("t5_shdr", bus.tap_state, 4'h6);
        for (int i = 0; i < 5; i++) begin
            edge_step(1'b1, 1'b1);
            chk($sformatf("t5_state%0d", i), bus.tap_state, exp5[i]);
            chk($sformatf("t5_done%0d", i), bus.scan_done, don5[i]);
        end
        chk("t5_nwr", wq.size(), 0);
        chk("t5_overrun", bus.overrun, 1'b1);
        edge_step(1'b0, 1'b0);

        // pause/resume DR scan
        wq.delete();
        bus.start_adr = 24'h000200; bus.len = 24'd16;
        to_shift(1'b0);
        shift(5, 32'h1F, 1'b1);
        chk("t4_ex1dr", bus.tap_state, 4'h8);
        chk("t4_flush_en", bus.wr_en, 1'b1);
        edge_step(1'b0, 1'b0);
        chk("t4_padr", bus.tap_state, 4'hA);
        edge_step(1'b1, 1'b0);
        chk("t4_ex2dr", bus.tap_state, 4'hC);
        edge_step(1'b0, 1'b0);
        chk("t4_resume", bus.tap_state, 4'h6);
        shift(11, 32'h0, 1'b1);
        edge_step(1'b1, 1'b0);
        edge_step(1'b0, 1'b0);
        chk("t4_bits", bus.bits_rcvd, 24'd16);
        chk("t4_overrun", bus.overrun, 1'b0);
        chk("t4_nwr", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("t4_wr0", wq[0], 32'h0002001F);
            chk("t4_wr1", wq[1], 32'h00020100);
            chk("t4_wr2", wq[2], 32'h00020200);
        end

        // capture disabled: tracker only
        wq.delete();
        bus.enable = 1'b0; bus.start_adr = 24'h000400; bus.len = 24'd8;
        to_shift(1'b0);
        shift(8, 32'hFF, 1'b1);
        chk("t6_ex1dr", bus.tap_state, 4'h8);
        edge_step(1'b1, 1'b0);
        chk("t6_updr", bus.tap_state, 4'hE);
        chk("t6_done", bus.scan_done, 1'b1);
        edge_step(1'b0, 1'b0);
        chk("t6_rti", bus.tap_state, 4'h1);
        chk("t6_nwr", wq.size(), 0);
        chk("t6_bits", bus.bits_rcvd, 24'd0);
        chk("t6_overrun", bus.overrun, 1'b0);
        bus.enable = 1'b1;

        // reset in the middle of a scan
        wq.delete();
        bus.start_adr = 24'h000500; bus.len = 24'd4;
        to_shift(1'b0);
        shift(7, 32'h7F, 1'b0);
        chk("t1_pre_state", bus.tap_state, 4'h6);
        chk("t1_pre_bits", bus.bits_rcvd, 24'd4);
        chk("t1_pre_overrun", bus.overrun, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t1_state", bus.tap_state, 4'h0);
        chk("t1_wr_en", bus.wr_en, 1'b0);
        chk("t1_overrun", bus.overrun, 1'b0);
        chk("t1_bits", bus.bits_rcvd, 24'd0);
        chk("t1_adr", bus.wr_adr, 24'h0);
        @(negedge clk);
        reset = 1'b0;
        bus.tms = 1'b0;
        @(posedge clk); #1;
        chk("t1_rti", bus.tap_state, 4'h1);
        chk("t1_nwr", wq.size(), 1);
        if (wq.size() > 0) chk("t1_wr0", wq[0], 32'h0005000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdi_capture_unit.md
Name: tdi_capture_unit

Overview:
Receive-side counterpart of the executor's TMS/TDO generator. It tracks the target TAP state from the TMS stream that the executor drives, and samples the target's serial response (tdi) during Shift-DR and Shift-IR. It packs the sampled bits LSB-first into bytes and writes them to capture RAM, starting at a programmable address. Its output feeds the executor's compare/readback path.

Parameters:
ADR_W, 24, width of the RAM address and of start_adr.
LEN_W, 24, width of the bit-length and bit-count fields.
DATA_W, 8, bits per RAM write word.

Ports:
clk_scan  input  1  scan clock (same net as tck); all logic on its rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  capture enable; the TAP tracker runs regardless of this input.
tms  input  1  TMS as driven to the target; changes on the falling edge of clk_scan.
tdi  input  1  serial response from the target TDO pin; valid at the rising edge.
start_adr  input  ADR_W  first RAM address; loaded in Capture-DR/IR.
len  input  LEN_W  number of bits to capture per scan; loaded in Capture-DR/IR.
wr_adr  output  ADR_W  RAM write address.
wr_data  output  DATA_W  RAM write data.
wr_en  output  1  one-cycle RAM write strobe.
tap_state  output  4  tracked TAP state, encoded 0..F (TLR=0, RTI=1, SELDR=2, SELIR=3, CAPDR=4, CAPIR=5, SHDR=6, SHIR=7, EX1DR=8, EX1IR=9, PADR=A, PAIR=B, EX2DR=C, EX2IR=D, UPDR=E, UPIR=F).
bits_rcvd  output  LEN_W  number of bits accepted in the current scan.
scan_done  output  1  one-cycle pulse on entry to UPDR/UPIR.
overrun  output  1  sticky flag: shift bits arrived beyond len.

Behaviour:
- Reset (asynchronous, high): tap_state=TLR; wr_adr, wr_data, wr_en, bits_rcvd, scan_done, overrun = 0; byte shift register and bit index = 0.
- TAP tracker:
  - Standard IEEE 1149.1 16-state FSM; transition on each rising clk_scan edge using tms.
  - Unused encodings are impossible. Any illegal value recovers to TLR.
- Capture-DR/IR (tracked state at the edge):
  - Load wr_adr<=start_adr and the remaining-bit counter<=len.
  - Clear bits_rcvd, bit index, shift register and overrun.
- Sampling:
  - At every rising edge where the tracked state is SHDR or SHIR, one bit is presented. This includes the exit edge with tms=1.
  - If enable=1 and remaining>0: accept the bit.
    - Place tdi at position bit index (LSB-first).
    - bits_rcvd+1, remaining-1, bit index+1.
  - If enable=1 and remaining=0: discard the bit and set overrun=1.
  - If enable=0: ignore the bit, with no counting and no overrun.
- Write issue:
  - wr_en=1 for exactly the cycle after the edge that completes a byte (bit index reaches DATA_W), or after a partial-byte flush.
  - wr_data is then the packed byte. Unfilled upper bits are 0.
  - wr_adr holds the write address during the wr_en cycle, then increments by 1 (mod 2^ADR_W, wrap silently).
- Flush: on exit from shift (SHxR with tms=1):
  - If the accepted bit index is nonzero, write the partial byte.
  - A byte completing on the exit edge produces exactly one write, not two.
  - A flush also occurs when remaining reaches 0 with a partial byte, still at most one write per byte.
- Pause (SHxR→EX1→PAxR→EX2→SHxR):
  - The partial byte is flushed at EX1 entry.
  - Resumed bits start a new byte at the next address.
  - Counters are not reloaded.
- scan_done: asserted for one cycle after the edge entering UPDR/UPIR. bits_rcvd holds its value until the next capture state.
- len=0: no writes occur; any shift bit sets overrun.
- Reset mid-scan: abort immediately. No flush or write is issued.
- TLR entry (e.g. 5× tms=1): the tracker goes to TLR. Counters hold, and no write is issued beyond a flush already due.

Decomposition:
- Shared package jtag_pkg holds:
  - the 4-bit TAP state encodings listed above;
  - ADR_W/LEN_W defaults;
  - a function next_tap_state(state, tms).
- One sub-module, tap_state_tracker (clk_scan, reset, tms → tap_state). It is reusable by the generator's dummy-FSM replacement.
- Packing, counters and write logic live in the top module.

Test Plan:
1. Reset asserted mid-operation → tap_state=0, wr_en=0, overrun=0, bits_rcvd=0 within the same cycle (asynchronous). After release, tms=0 → tap_state=1.
2. DR scan, start_adr=0x000100, len=12, tdi bits LSB-first 0xA5 then 0x3 (nibble) → write 0xA5@0x000100, then 0x03@0x000101 on the exit flush. bits_rcvd=12, scan_done pulses once.
3. IR scan, len=8, 10 shift edges → one write of the first 8 bits; overrun=1; bits_rcvd=8.
4. DR scan, len=16, pause after 5 bits (tdi=1s), resume 11 bits 0 → writes 0x1F@A, 0x00@A+1, 0x00@A+2 (0x00 is the partial-byte flush of 3 zeros); bits_rcvd=16.
5. From SHDR, drive tms=1 for 5 edges → tap_state reaches 0 via EX1DR/UPDR/SELDR/SELIR; scan_done pulses at UPDR; no spurious writes.
6. enable=0 during a full 8-bit DR scan → no writes, bits_rcvd=0, overrun=0; the tracker still follows TMS.
